otp_auth_engine: RTL

Parametrised one-time-passcode authentication engine. It is the successor to the fixed 4-bit/single-try authenticator in the TinyTapeout top level. A free-running LFSR supplies a DIGITS-nibble OTP on request. The user enters the OTP back one nibble at a time, and the block compares the entry against the issued code. It adds an OTP expiry window, a single-use code, a retry counter and a timed lockout; the top-level wrapper drives display multiplexing and pin mapping from its outputs.

---
 rtl/otp_auth_pkg.sv | 23 ++
 rtl/otp_lfsr.sv | 32 +++
 rtl/otp_auth_engine.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/otp_auth_pkg.sv
// Shared types and helpers for the one-time-passcode authentication engine.
package otp_auth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_PASS,
        S_FAIL,
        S_LOCK
    } state_e;

    // Galois (right-shift) masks for maximal-length polynomials; bit k set for term x^(k+1).
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Free-running Galois LFSR; advances every cycle and restarts from SEED on reset.
module otp_lfsr
    import otp_auth_pkg::*;
#(
    parameter int unsigned    W    = 16,
    parameter logic [W-1:0]   SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] state_o
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/otp_auth_engine.sv
// OTP authenticator: issues an LFSR-derived code, collects the user's entry nibble
// by nibble, and enforces expiry, single use, a retry budget and a timed lockout.
module otp_auth_engine
    import otp_auth_pkg::*;
#(
    parameter int unsigned       DIGITS        = 4,
    parameter int unsigned       LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
    parameter int unsigned       MAX_TRIES     = 3,
    parameter int unsigned       EXPIRE_CYCLES = 1024,
    parameter int unsigned       LOCK_CYCLES   = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     user_in,
    input  logic                           otp_req,
    input  logic                           digit_latch,
    output logic [4*DIGITS-1:0]            otp_code,
    output logic                           otp_valid,
    output logic [$clog2(DIGITS+1)-1:0]    entry_count,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic                           auth_ok,
    output logic                           auth_fail,
    output logic                           fail_expired,
    output logic                           locked
);

    localparam int unsigned CW  = 4 * DIGITS;
    localparam int unsigned ECW = $clog2(DIGITS + 1);
    localparam int unsigned TRW = $clog2(MAX_TRIES + 1);
    localparam int unsigned EXW = $clog2(EXPIRE_CYCLES + 1);
    localparam int unsigned LKW = $clog2(LOCK_CYCLES + 1);

    localparam logic [ECW-1:0] CNT_FULL  = ECW'(DIGITS);
    localparam logic [ECW-1:0] CNT_LAST  = ECW'(DIGITS - 1);
    localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);
    localparam logic [EXW-1:0] EXP_LAST  = EXW'(EXPIRE_CYCLES - 1);
    localparam logic [LKW-1:0] LOCK_LAST = LKW'(LOCK_CYCLES - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("otp_auth_engine: DIGITS must be 1..8");
    end
    if (LFSR_W != 16 && LFSR_W != 24 && LFSR_W != 32) begin : g_bad_width
        $error("otp_auth_engine: LFSR_W must be 16, 24 or 32");
    end
    if (LFSR_W < CW) begin : g_narrow_lfsr
        $error("otp_auth_engine: LFSR_W must be at least 4*DIGITS");
    end
    if (SEED == '0) begin : g_zero_seed
        $error("otp_auth_engine: SEED must be nonzero");
    end
    if (MAX_TRIES < 1 || EXPIRE_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_bad_counts
        $error("otp_auth_engine: MAX_TRIES, EXPIRE_CYCLES and LOCK_CYCLES must be >= 1");
    end

    logic [LFSR_W-1:0] lfsr_state;

    otp_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr_state)
    );

    state_e         state_q,   state_d;
    logic [CW-1:0]  code_q,    code_d;
    logic [CW-1:0]  entry_q,   entry_d;
    logic [ECW-1:0] cnt_q,     cnt_d;
    logic [TRW-1:0] tries_q,   tries_d;
    logic [EXW-1:0] exp_tmr_q, exp_tmr_d;
    logic [LKW-1:0] lock_tmr_q, lock_tmr_d;
    logic           expired_q, expired_d;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        tries_d    = tries_q;
        exp_tmr_d  = exp_tmr_q;
        lock_tmr_d = lock_tmr_q;
        expired_d  = expired_q;

        case (state_q)
            S_IDLE: begin
                if (otp_req) begin
                    state_d   = S_ENTRY;
                    code_d    = lfsr_state[CW-1:0];
                    entry_d   = '0;
                    cnt_d     = '0;
                    exp_tmr_d = '0;
                    expired_d = 1'b0;
                end
            end
            S_ENTRY: begin
                // Expiry is tested first so it wins over a simultaneous final latch.
                if (exp_tmr_q == EXP_LAST) begin
                    state_d   = S_FAIL;
                    expired_d = 1'b1;
                    code_d    = '0;
                end else begin
                    exp_tmr_d = exp_tmr_q + 1'b1;
                    if (digit_latch && cnt_q != CNT_FULL) begin
                        for (int unsigned i = 0; i < DIGITS; i++) begin
                            if (cnt_q == ECW'(i)) begin
                                entry_d[4*i +: 4] = user_in;
                            end
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                code_d  = '0;
                state_d = (entry_q == code_q) ? S_PASS : S_FAIL;
            end
            S_PASS: begin
                tries_d = TRIES_MAX;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                tries_d = (tries_q != '0) ? tries_q - 1'b1 : '0;
                if (tries_q <= TRW'(1)) begin
                    state_d    = S_LOCK;
                    lock_tmr_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                if (lock_tmr_q == LOCK_LAST) begin
                    tries_d = TRIES_MAX;
                    state_d = S_IDLE;
                end else begin
                    lock_tmr_d = lock_tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            entry_q    <= '0;
            cnt_q      <= '0;
            tries_q    <= TRIES_MAX;
            exp_tmr_q  <= '0;
            lock_tmr_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            exp_tmr_q  <= exp_tmr_d;
            lock_tmr_q <= lock_tmr_d;
            expired_q  <= expired_d;
        end
    end

    assign otp_valid    = (state_q == S_ENTRY);
    assign otp_code     = otp_valid ? code_q : '0;
    assign entry_count  = cnt_q;
    assign tries_left   = tries_q;
    assign auth_ok      = (state_q == S_PASS);
    assign auth_fail    = (state_q == S_FAIL);
    assign fail_expired = (state_q == S_FAIL) && expired_q;
    assign locked       = (state_q == S_LOCK);

endmodule
